// File: rtl/fir_pkg.sv
// Shared types and widths for the FIR decimator slice.
package fir_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } dec_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is read straight from the
// storage array, so a pushed word becomes visible after its write edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when a pop frees a slot on the same edge.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Status flags and head word, forced to zero while empty.
  always_comb begin
    full  = (count == FULL_CNT);
    empty = (count == '0);
    dout  = empty ? '0 : mem[rptr];
  end

endmodule

// File: rtl/fir_decimator.sv
// Decimates a qualified sample stream after discarding a pipeline-fill prefix,
// buffering the kept samples in an output FIFO with drop accounting.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int SKIP  = 3,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                in_valid,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic [15:0]         drop_cnt
);

  // With no fill to skip the reset state is already RUN, which is
  // behaviourally identical to a warm-up that ends before any sample.
  localparam dec_state_t START_STATE = (SKIP == 0) ? RUN : WARMUP;
  localparam logic [7:0] SKIP_LAST   = 8'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [3:0] PHASE_LAST  = 4'(DECIM - 1);

  dec_state_t state;
  logic [7:0] skip_cnt;
  logic [3:0] phase;
  logic       push_req;
  logic       pop;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;

  // Keep a valid sample only in RUN at phase 0; detect drops on a blocked full FIFO.
  always_comb begin
    push_req  = in_valid & (state == RUN) & (phase == '0);
    pop       = out_ready & ~fifo_empty;
    drop      = push_req & fifo_full & ~pop;
    out_valid = ~fifo_empty;
  end

  // Warm-up skip counter and decimation phase, advanced only by valid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= START_STATE;
      skip_cnt <= '0;
      phase    <= '0;
    end else if (in_valid) begin
      case (state)
        WARMUP: begin
          if (skip_cnt == SKIP_LAST) begin
            state    <= RUN;
            skip_cnt <= '0;
            phase    <= '0;
          end else begin
            skip_cnt <= skip_cnt + 1'b1;
          end
        end
        RUN: begin
          if (phase == PHASE_LAST) phase <= '0;
          else                     phase <= phase + 1'b1;
        end
        default: state <= START_STATE;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (in_sample),
    .dout  (out_sample),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: two instances (DECIM=4/SKIP=3 and DECIM=1/SKIP=0),
// each compared every cycle against a sample-index/queue reference model.
module tb_fir_decimator;

  localparam int DEC_A = 4;
  localparam int SKP_A = 3;
  localparam int DEC_B = 1;
  localparam int SKP_B = 0;
  localparam int DEP   = 8;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic        vld_a = 1'b0, vld_b = 1'b0;
  logic        rdy_a = 1'b0, rdy_b = 1'b0;
  logic [15:0] out_a, out_b, drop_a, drop_b;
  logic        ov_a, ov_b, ovf_a, ovf_b;

  int errors = 0;
  int checks = 0;

  // reference state
  int na = 0, nb = 0;
  int qa[$], qb[$];
  bit mova = 0, movb = 0;
  int mdra = 0, mdrb = 0;
  int cap_a[$], cap_b[$];

  always #5 clk = ~clk;

  fir_decimator #(.DECIM(DEC_A), .SKIP(SKP_A), .DEPTH(DEP)) u_a (
    .clk(clk), .rst(rst_a), .in_sample(in_a), .in_valid(vld_a),
    .out_sample(out_a), .out_valid(ov_a), .out_ready(rdy_a),
    .overflow(ovf_a), .drop_cnt(drop_a));

  fir_decimator #(.DECIM(DEC_B), .SKIP(SKP_B), .DEPTH(DEP)) u_b (
    .clk(clk), .rst(rst_b), .in_sample(in_b), .in_valid(vld_b),
    .out_sample(out_b), .out_valid(ov_b), .out_ready(rdy_b),
    .overflow(ovf_b), .drop_cnt(drop_b));

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_seq(input string nm, input int got[$], input int exp[$]);
    cmp({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) cmp(nm, got[i], exp[i]);
  endtask

  // Model A: valid sample k (counted from reset) is kept iff k>=SKIP and (k-SKIP)%DECIM==0.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      na = 0; qa.delete(); mova = 0; mdra = 0;
    end else begin
      bit popm, pushm;
      popm  = (qa.size() > 0) && rdy_a;
      pushm = 0;
      if (vld_a) begin
        if (na >= SKP_A && ((na - SKP_A) % DEC_A) == 0) pushm = 1;
        na++;
      end
      if (popm) void'(qa.pop_front());
      if (pushm) begin
        if (qa.size() < DEP) qa.push_back(int'($signed(in_a)));
        else begin mova = 1; if (mdra < 65535) mdra++; end
      end
    end
  end

  // Model B, same rules with its own parameters.
  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      nb = 0; qb.delete(); movb = 0; mdrb = 0;
    end else begin
      bit popm, pushm;
      popm  = (qb.size() > 0) && rdy_b;
      pushm = 0;
      if (vld_b) begin
        if (nb >= SKP_B && ((nb - SKP_B) % DEC_B) == 0) pushm = 1;
        nb++;
      end
      if (popm) void'(qb.pop_front());
      if (pushm) begin
        if (qb.size() < DEP) qb.push_back(int'($signed(in_b)));
        else begin movb = 1; if (mdrb < 65535) mdrb++; end
      end
    end
  end

  // Per-cycle compare against the models, plus capture of accepted outputs.
  always @(negedge clk) begin
    cmp("a_valid", int'(ov_a), int'(qa.size() > 0));
    if (qa.size() > 0) cmp("a_sample", int'($signed(out_a)), qa[0]);
    if (rst_a) cmp("a_sample_rst", int'(out_a), 0);
    cmp("a_overflow", int'(ovf_a), int'(mova));
    cmp("a_drop_cnt", int'(drop_a), mdra);
    cmp("b_valid", int'(ov_b), int'(qb.size() > 0));
    if (qb.size() > 0) cmp("b_sample", int'($signed(out_b)), qb[0]);
    if (rst_b) cmp("b_sample_rst", int'(out_b), 0);
    cmp("b_overflow", int'(ovf_b), int'(movb));
    cmp("b_drop_cnt", int'(drop_b), mdrb);
    if (ov_a && rdy_a) cap_a.push_back(int'($signed(out_a)));
    if (ov_b && rdy_b) cap_b.push_back(int'($signed(out_b)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_q[$];

    // reset values
    tick(); tick();
    @(negedge clk);
    cmp("rst_a_valid", int'(ov_a), 0);
    cmp("rst_a_sample", int'(out_a), 0);
    cmp("rst_a_ovf", int'(ovf_a), 0);
    cmp("rst_a_drop", int'(drop_a), 0);
    cmp("rst_b_valid", int'(ov_b), 0);
    tick();
    rst_a = 1'b0; rst_b = 1'b0;

    // 1..20 every cycle, ready held high
    rdy_a = 1'b1;
    cap_a.delete();
    for (int i = 1; i <= 20; i++) begin
      vld_a = 1'b1; in_a = 16'(i); tick();
    end
    vld_a = 1'b0;
    repeat (3) tick();
    exp_q = '{4, 8, 12, 16, 20};
    cmp_seq("seq_dense", cap_a, exp_q);
    cmp("dense_ovf", int'(ovf_a), 0);

    // same stream with idle cycles interleaved
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    cap_a.delete();
    for (int i = 1; i <= 20; i++) begin
      vld_a = 1'b1; in_a = 16'(i); tick();
      vld_a = 1'b0; tick();
    end
    repeat (3) tick();
    cmp_seq("seq_sparse", cap_a, exp_q);

    // DECIM=1: fill with -100..-91 while blocked, two must drop
    rdy_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vld_b = 1'b1; in_b = 16'(-100 + i); tick();
    end
    vld_b = 1'b0;
    @(negedge clk);
    cmp("fill_ovf", int'(ovf_b), 1);
    cmp("fill_drop", int'(drop_b), 2);
    cmp("fill_head", int'($signed(out_b)), -100);
    tick();
    cap_b.delete();
    rdy_b = 1'b1;
    repeat (10) tick();
    exp_q = '{-100, -99, -98, -97, -96, -95, -94, -93};
    cmp_seq("drain", cap_b, exp_q);

    // full FIFO: simultaneous push and pop must not drop
    rdy_b = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      vld_b = 1'b1; in_b = 16'(i); tick();
    end
    vld_b = 1'b1; in_b = 16'(9); rdy_b = 1'b1; tick();
    vld_b = 1'b0; rdy_b = 1'b0;
    @(negedge clk);
    cmp("pp_drop", int'(drop_b), 2);
    cmp("pp_head", int'($signed(out_b)), 2);
    tick();
    cap_b.delete();
    rdy_b = 1'b1;
    repeat (10) tick();
    exp_q = '{2, 3, 4, 5, 6, 7, 8, 9};
    cmp_seq("pp_occupancy", cap_b, exp_q);

    // reset between edges with 5 entries buffered
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    rdy_a = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      vld_a = 1'b1; in_a = 16'(i); tick();
    end
    vld_a = 1'b0;
    @(negedge clk);
    cmp("pre_rst_valid", int'(ov_a), 1);
    @(posedge clk); #2;
    rst_a = 1'b1;
    #1;
    cmp("midrst_valid", int'(ov_a), 0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    cap_a.delete();
    rdy_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vld_a = 1'b1; in_a = 16'(i); tick();
    end
    vld_a = 1'b0;
    repeat (3) tick();
    exp_q = '{4, 8};
    cmp_seq("post_rst", cap_a, exp_q);

    // randomized traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      vld_a = 1'($urandom_range(0, 3) != 0);
      vld_b = 1'($urandom_range(0, 1));
      in_a  = 16'($urandom);
      in_b  = 16'($urandom);
      rdy_a = 1'($urandom_range(0, 9) < 2);
      rdy_b = 1'($urandom_range(0, 9) < 6);
      rst_a = 1'($urandom_range(0, 199) == 0);
      rst_b = 1'($urandom_range(0, 299) == 0);
      tick();
    end
    rst_a = 1'b0; rst_b = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 The module SHALL have parameter DECIM, default 4, meaning the decimation factor (legal range 1..16).
REQ-002 The module SHALL have parameter SKIP, default 3, meaning the number of leading valid samples discarded as filter pipeline fill (0..255).
REQ-003 The module SHALL have parameter DEPTH, default 8, meaning the output FIFO depth in samples (power of 2, 2..64).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_sample  input  16  signed filter output (driven by fir_filter output_signal).
REQ-007 in_valid  input  1  in_sample qualifier; sampled on every rising clk edge.
REQ-008 out_sample  output  16  signed decimated sample at FIFO head.
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 out_ready  input  1  consumer accepts out_sample this cycle.
REQ-011 overflow  output  1  sticky flag: at least one decimated sample dropped.
REQ-012 drop_cnt  output  16  count of dropped decimated samples, saturating at 16'hFFFF.

Function
REQ-013 States SHALL be WARMUP and RUN; WARMUP SHALL discard SKIP valid samples, then transition to RUN on the edge that consumes the SKIP-th one; with SKIP=0 the block SHALL enter RUN directly out of reset.
REQ-014 In RUN, a phase counter SHALL count valid samples 0..DECIM-1 and wrap to 0; it SHALL start at 0 on entry to RUN.
REQ-015 A valid sample taken while phase==0 SHALL be pushed to the FIFO; all other samples SHALL be discarded.
REQ-016 Cycles with in_valid=0 SHALL change neither the phase nor the WARMUP count.
REQ-017 A pushed sample SHALL appear on out_sample with out_valid=1 one cycle after its input edge, with no combinational fall-through.
REQ-018 A pop SHALL occur on any edge where out_valid and out_ready are both 1; out_sample SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 A push into a full FIFO SHALL be accepted if a pop occurs on the same edge; otherwise the sample SHALL be dropped, overflow set, and drop_cnt incremented.
REQ-020 A simultaneous push and pop on an empty FIFO is impossible, since out_valid=0; a push and pop on a non-empty FIFO SHALL leave the occupancy unchanged.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked so that full and empty are unambiguous.
REQ-022 Sample values SHALL pass bit-exact, with no scaling or rounding.
REQ-023 overflow SHALL remain 1 until reset; drop_cnt SHALL saturate and never wrap.

Reset
REQ-024 While rst=1, the state SHALL be WARMUP, the skip count and phase 0, the FIFO empty, out_valid=0, out_sample=0, overflow=0 and drop_cnt=0.
REQ-025 Reset asserted mid-operation SHALL discard FIFO contents immediately (asynchronously), and a new warm-up SHALL begin after release.
REQ-026 The first rising edge after rst deasserts SHALL be processed as a normal cycle.

Structure
REQ-027 The shared package fir_pkg SHALL hold SAMPLE_W=16 and the state enumeration {WARMUP, RUN}.
REQ-028 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty); the decimator control SHALL live in fir_decimator.

Verification
REQ-029 With DECIM=4, SKIP=3, out_ready=1, and inputs 1,2,3,...,20 valid every cycle, the outputs SHALL be 4,8,12,16,20, each one cycle after its input, with overflow=0.
REQ-030 With the same inputs but in_valid=0 on every second cycle, the output sequence SHALL be identical, with timing stretched accordingly.
REQ-031 With DECIM=1, SKIP=0, DEPTH=8, out_ready=0, and 10 valid samples of -100..-91, the FIFO SHALL hold -100..-93, with overflow=1 and drop_cnt=2; raising out_ready SHALL then drain -100..-93 in order.
REQ-032 On a full FIFO with push and pop on the same edge, no drop SHALL occur and occupancy SHALL stay 8.
REQ-033 Asserting rst between clock edges with 5 entries buffered SHALL drop out_valid to 0 immediately; after release, the next SKIP samples SHALL be discarded again.
REQ-034 Driving fir_filter with input_signal_1.txt (2400 samples) into fir_decimator at DECIM=4 SHALL produce 600 outputs matching every 4th reference filter output after the 3-sample pipeline fill.
